// File: rtl/dmem_port_arbiter_pkg.sv
// Shared encodings and the captured-slot record for the data-memory port arbiter.
package dmem_port_arbiter_pkg;

  localparam int NUM_SLOTS = 2;

  localparam logic [1:0] MEM_OP_NONE  = 2'd0;
  localparam logic [1:0] MEM_OP_LOAD  = 2'd1;
  localparam logic [1:0] MEM_OP_STORE = 2'd2;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // One slot's memory access, already lane-formatted at capture time.
  typedef struct packed {
    logic        load;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } slot_req_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Per-slot byte-lane formatter: write enables, replicated store data, alignment check.
module dmem_lane_fmt
  import dmem_port_arbiter_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic [3:0]  we,
  output logic [31:0] wdata_rep,
  output logic        misaligned
);

  always_comb begin
    we        = 4'h0;
    wdata_rep = wdata;
    case (size)
      SIZE_B: begin
        we        = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
      end
      SIZE_H: begin
        we        = 4'b0011 << off;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: we = 4'hF;
    endcase
    if (op != MEM_OP_STORE) we = 4'h0;
    // An empty slot never reports an alignment error.
    misaligned = (op != MEM_OP_NONE) && is_misaligned(size, off);
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Serializes the two MEM-stage slots onto one data-memory port, slot 1 first,
// stalling the pipeline until both complete; flags misalignment and timeouts.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_stage_valid,
  input  logic        flush,
  input  logic [1:0]  slot1_op,
  input  logic [1:0]  slot1_size,
  input  logic [31:0] slot1_addr,
  input  logic [31:0] slot1_wdata,
  input  logic [1:0]  slot2_op,
  input  logic [1:0]  slot2_size,
  input  logic [31:0] slot2_addr,
  input  logic [31:0] slot2_wdata,
  output logic [31:0] slot1_rdata,
  output logic [31:0] slot2_rdata,
  output logic        stall,
  output logic        mem_req,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  err_misaligned,
  output logic        err_timeout
);

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [NUM_SLOTS-1:0][1:0]  op_in, size_in;
  logic [NUM_SLOTS-1:0][31:0] addr_in, wdata_in;
  logic [NUM_SLOTS-1:0][3:0]  fmt_we;
  logic [NUM_SLOTS-1:0][31:0] fmt_wdata;
  logic [NUM_SLOTS-1:0]       fmt_mis;
  logic [NUM_SLOTS-1:0]       cap_act;
  slot_req_t [NUM_SLOTS-1:0]  cap, slot_q;
  logic [NUM_SLOTS-1:0][31:0] rdata_q;
  logic [NUM_SLOTS-1:0]       mis_q;

  state_t     state;
  logic [7:0] wait_cnt;
  logic       slot2_pend, flush_seen;
  logic       capture, in_acc, cur, timeout_hit, acc_end;

  assign op_in    = {slot2_op, slot1_op};
  assign size_in  = {slot2_size, slot1_size};
  assign addr_in  = {slot2_addr, slot1_addr};
  assign wdata_in = {slot2_wdata, slot1_wdata};

  generate
    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_fmt
      dmem_lane_fmt u_fmt (
        .op         (op_in[i]),
        .size       (size_in[i]),
        .off        (addr_in[i][1:0]),
        .wdata      (wdata_in[i]),
        .we         (fmt_we[i]),
        .wdata_rep  (fmt_wdata[i]),
        .misaligned (fmt_mis[i])
      );
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      cap_act[i]   = (op_in[i] != MEM_OP_NONE) && !fmt_mis[i];
      cap[i].load  = op_in[i] == MEM_OP_LOAD;
      cap[i].we    = fmt_we[i];
      cap[i].addr  = {addr_in[i][31:2], 2'b00};
      cap[i].wdata = fmt_wdata[i];
    end
  end

  assign capture = (state == IDLE) && mem_stage_valid && !flush &&
                   ((slot1_op != MEM_OP_NONE) || (slot2_op != MEM_OP_NONE));
  assign in_acc  = (state == ACC1) || (state == ACC2);
  assign cur     = state == ACC2;

  // Abandon on the TIMEOUT-th unacknowledged request cycle.
  assign timeout_hit = in_acc && !mem_ack && (wait_cnt == WAIT_LAST);
  assign acc_end     = in_acc && (mem_ack || timeout_hit);

  // IDLE stall is combinational so the capture cycle itself is frozen.
  assign stall          = !rst && (capture || in_acc);
  assign mem_req        = in_acc;
  assign mem_we         = in_acc ? slot_q[cur].we    : 4'h0;
  assign mem_addr       = in_acc ? slot_q[cur].addr  : 32'h0;
  assign mem_wdata      = in_acc ? slot_q[cur].wdata : 32'h0;
  assign err_misaligned = (state == DONE) ? mis_q : 2'b00;
  assign slot1_rdata    = rdata_q[0];
  assign slot2_rdata    = rdata_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      slot_q      <= '0;
      rdata_q     <= '0;
      mis_q       <= '0;
      slot2_pend  <= 1'b0;
      flush_seen  <= 1'b0;
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (capture) begin
            slot_q     <= cap;
            mis_q      <= fmt_mis;
            slot2_pend <= cap_act[1];
            rdata_q    <= '0;
            flush_seen <= 1'b0;
            wait_cnt   <= '0;
            if (cap_act[0])      state <= ACC1;
            else if (cap_act[1]) state <= ACC2;
            else                 state <= DONE;
          end
        end
        ACC1, ACC2: begin
          if (flush) flush_seen <= 1'b1;
          if (acc_end) begin
            wait_cnt <= '0;
            if (slot_q[cur].load) rdata_q[cur] <= mem_ack ? mem_rdata : 32'h0;
            if (!mem_ack) err_timeout <= 1'b1;
            if ((state == ACC1) && slot2_pend && !flush_seen && !flush)
              state <= ACC2;
            else
              state <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench: stimulus pushes expected requests/completions, a monitor checks them.
module tb_dmem_port_arbiter;
  import dmem_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst, mem_stage_valid, flush;
  logic [1:0]  slot1_op, slot1_size, slot2_op, slot2_size;
  logic [31:0] slot1_addr, slot1_wdata, slot2_addr, slot2_wdata;
  logic [31:0] slot1_rdata, slot2_rdata;
  logic        stall, mem_req, mem_ack, err_timeout;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  err_misaligned;

  dmem_port_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .mem_stage_valid(mem_stage_valid), .flush(flush),
    .slot1_op(slot1_op), .slot1_size(slot1_size), .slot1_addr(slot1_addr), .slot1_wdata(slot1_wdata),
    .slot2_op(slot2_op), .slot2_size(slot2_size), .slot2_addr(slot2_addr), .slot2_wdata(slot2_wdata),
    .slot1_rdata(slot1_rdata), .slot2_rdata(slot2_rdata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .err_misaligned(err_misaligned), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [3:0] we; logic [31:0] wdata; } req_exp_t;
  typedef struct { logic [31:0] r1, r2; logic [1:0] mis; logic to; int stalls; } done_exp_t;

  req_exp_t  req_q[$];
  done_exp_t done_q[$];
  int n_pass = 0, n_total = 0;
  int ack_delay = 0, wcnt = 0, stall_run = 0;
  bit mon_en = 0;
  logic [31:0] mem_arr [int unsigned];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endfunction

  function automatic logic [31:0] rd_word(logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : 32'h0;
  endfunction

  // Memory responder: acks after ack_delay unacknowledged request cycles.
  always @(negedge clk) begin
    if (mem_req && !rst) begin
      if (wcnt >= ack_delay) begin
        logic [31:0] w;
        mem_ack = 1'b1;
        wcnt = 0;
        w = rd_word(mem_addr);
        if (mem_we == 4'h0) mem_rdata = w;
        else begin
          for (int b = 0; b < 4; b++)
            if (mem_we[b]) w[b*8 +: 8] = mem_wdata[b*8 +: 8];
          mem_arr[mem_addr] = w;
          mem_rdata = 32'hBAD0BAD0;
        end
      end else begin
        mem_ack = 1'b0;
        mem_rdata = 32'hBAD0BAD0;
        wcnt++;
      end
    end else begin
      mem_ack = 1'b0;
      mem_rdata = 32'hBAD0BAD0;
      wcnt = 0;
    end
  end

  // Monitor: checks each acknowledged request and each completion (first stall-low cycle).
  req_exp_t  re;
  done_exp_t de;
  always @(negedge clk) begin
    #2;
    if (rst || !mon_en) stall_run = 0;
    else begin
      if (mem_req && mem_ack) begin
        if (req_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_req: got addr 0x%08h expected none", mem_addr);
        end else begin
          re = req_q.pop_front();
          chk("req_addr", mem_addr, re.addr);
          chk("req_we", 32'(mem_we), 32'(re.we));
          chk("req_wdata", mem_wdata, re.wdata);
        end
      end
      if (stall) stall_run++;
      else if (stall_run > 0) begin
        if (done_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_done: got stall run %0d expected none", stall_run);
        end else begin
          de = done_q.pop_front();
          chk("stall_cycles", 32'(stall_run), 32'(de.stalls));
          chk("slot1_rdata", slot1_rdata, de.r1);
          chk("slot2_rdata", slot2_rdata, de.r2);
          chk("err_misaligned", 32'(err_misaligned), 32'(de.mis));
          chk("err_timeout", 32'(err_timeout), 32'(de.to));
        end
        stall_run = 0;
      end
    end
  end

  task automatic exp_req(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
    req_q.push_back('{addr: a, we: we, wdata: wd});
  endtask

  task automatic exp_done(input logic [31:0] r1, r2, input logic [1:0] mis, input logic to, input int st);
    done_q.push_back('{r1: r1, r2: r2, mis: mis, to: to, stalls: st});
  endtask

  task automatic set_slots(input logic [1:0] o1, s1, input logic [31:0] a1, d1,
                           input logic [1:0] o2, s2, input logic [31:0] a2, d2);
    slot1_op = o1; slot1_size = s1; slot1_addr = a1; slot1_wdata = d1;
    slot2_op = o2; slot2_size = s2; slot2_addr = a2; slot2_wdata = d2;
  endtask

  // Presents the pair until the DONE cycle, optionally pulsing flush k cycles after capture.
  task automatic run_pair(input int flush_k);
    bit seen = 0;
    @(posedge clk); #1;
    mem_stage_valid = 1'b1;
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(posedge clk); #1;
      flush = (k == flush_k);
      if (!stall) seen = 1;
    end
    flush = 1'b0;
    if (!seen) begin
      n_total++;
      $display("FAIL done_wait: got no DONE expected within 60 cycles");
    end
    @(posedge clk); #1;
    mem_stage_valid = 1'b0;
    set_slots(MEM_OP_NONE, SIZE_W, 0, 0, MEM_OP_NONE, SIZE_W, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1);
  end

  initial begin
    bit hit = 0;
    rst = 1'b1; mem_stage_valid = 1'b0; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    set_slots(MEM_OP_NONE, SIZE_W, 0, 0, MEM_OP_NONE, SIZE_W, 0, 0);
    mem_arr[32'h100] = 32'h12345678;
    mem_arr[32'h204] = 32'hCAFEF00D;
    mem_arr[32'h400] = 32'h11112222;
    mem_arr[32'h600] = 32'h600D600D;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_err_timeout", 32'(err_timeout), 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Flush in IDLE: no stall, no capture.
    @(posedge clk); #1;
    set_slots(MEM_OP_LOAD, SIZE_W, 32'h100, 0, MEM_OP_NONE, SIZE_W, 0, 0);
    mem_stage_valid = 1'b1; flush = 1'b1;
    #1 chk("idle_flush_stall", 32'(stall), 0);
    @(posedge clk); #1;
    chk("idle_flush_no_req", 32'(mem_req), 0);
    mem_stage_valid = 1'b0; flush = 1'b0;

    // Single LW, zero-wait.
    ack_delay = 0;
    set_slots(MEM_OP_LOAD, SIZE_W, 32'h100, 0, MEM_OP_NONE, SIZE_W, 0, 0);
    exp_req(32'h100, 4'h0, 32'h0);
    exp_done(32'h12345678, 0, 2'b00, 0, 2);
    run_pair(0);

    // SB then LW of the same word: store lands first.
    set_slots(MEM_OP_STORE, SIZE_B, 32'h103, 32'h000000AB, MEM_OP_LOAD, SIZE_W, 32'h100, 0);
    exp_req(32'h100, 4'b1000, 32'hABABABAB);
    exp_req(32'h100, 4'h0, 32'h0);
    exp_done(0, 32'hAB345678, 2'b00, 0, 3);
    run_pair(0);

    // Misaligned LH skipped, LW still issued.
    set_slots(MEM_OP_LOAD, SIZE_H, 32'h201, 0, MEM_OP_LOAD, SIZE_W, 32'h204, 0);
    exp_req(32'h204, 4'h0, 32'h0);
    exp_done(0, 32'hCAFEF00D, 2'b01, 0, 2);
    run_pair(0);

    // Two stores with one wait cycle each.
    ack_delay = 1;
    set_slots(MEM_OP_STORE, SIZE_H, 32'h302, 32'h1234BEEF, MEM_OP_STORE, SIZE_W, 32'h300, 32'h55AA55AA);
    exp_req(32'h300, 4'b1100, 32'hBEEFBEEF);
    exp_req(32'h300, 4'hF, 32'h55AA55AA);
    exp_done(0, 0, 2'b00, 0, 5);
    run_pair(0);

    // Both misaligned: no requests, one stall cycle.
    ack_delay = 0;
    set_slots(MEM_OP_LOAD, SIZE_W, 32'h102, 0, MEM_OP_STORE, SIZE_H, 32'h305, 32'h1);
    exp_done(0, 0, 2'b11, 0, 1);
    run_pair(0);

    // Slot 2 only.
    set_slots(MEM_OP_NONE, SIZE_W, 0, 0, MEM_OP_LOAD, SIZE_B, 32'h101, 0);
    exp_req(32'h100, 4'h0, 32'h0);
    exp_done(0, 32'hAB345678, 2'b00, 0, 2);
    run_pair(0);

    // Timeout: 4 request cycles, then DONE with sticky error.
    ack_delay = 1000;
    set_slots(MEM_OP_LOAD, SIZE_W, 32'h500, 0, MEM_OP_NONE, SIZE_W, 0, 0);
    exp_done(0, 0, 2'b00, 1, 5);
    run_pair(0);

    // Flush during ACC1, ack after 3 waits (last cycle before timeout): no slot-2 access.
    ack_delay = 3;
    set_slots(MEM_OP_LOAD, SIZE_W, 32'h400, 0, MEM_OP_LOAD, SIZE_W, 32'h404, 0);
    exp_req(32'h400, 4'h0, 32'h0);
    exp_done(32'h11112222, 0, 2'b00, 1, 5);
    run_pair(2);

    // Asynchronous reset in the middle of ACC2.
    ack_delay = 2;
    set_slots(MEM_OP_LOAD, SIZE_W, 32'h600, 0, MEM_OP_LOAD, SIZE_W, 32'h604, 0);
    exp_req(32'h600, 4'h0, 32'h0);
    @(posedge clk); #1;
    mem_stage_valid = 1'b1;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk); #3;
      if (mem_req && mem_addr == 32'h604) hit = 1;
    end
    chk("acc2_reached", 32'(hit), 1);
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_async_stall", 32'(stall), 0);
    chk("rst_async_mem_req", 32'(mem_req), 0);
    chk("rst_async_mem_we", 32'(mem_we), 0);
    chk("rst_async_mem_addr", mem_addr, 0);
    chk("rst_async_mem_wdata", mem_wdata, 0);
    chk("rst_async_slot1_rdata", slot1_rdata, 0);
    chk("rst_async_err_timeout", 32'(err_timeout), 0);
    chk("rst_async_err_mis", 32'(err_misaligned), 0);
    mem_stage_valid = 1'b0;
    set_slots(MEM_OP_NONE, SIZE_W, 0, 0, MEM_OP_NONE, SIZE_W, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // Recovery after reset.
    ack_delay = 0;
    set_slots(MEM_OP_LOAD, SIZE_W, 32'h600, 0, MEM_OP_NONE, SIZE_W, 0, 0);
    exp_req(32'h600, 4'h0, 32'h0);
    exp_done(32'h600D600D, 0, 2'b00, 0, 2);
    run_pair(0);

    repeat (3) @(posedge clk);
    #1;
    chk("req_queue_drained", 32'(req_q.size()), 0);
    chk("done_queue_drained", 32'(done_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
